// File: rtl/encrypt_cipher_pkg.sv
// Shared types, constants and mod-26 helpers for the rotate-cipher pipeline stage.
package encrypt_cipher_pkg;

    localparam int ALPHA_N    = 26;
    localparam int UPPER_BASE = 65;
    localparam int LOWER_BASE = 97;

    typedef logic [4:0] alpha_idx_t;

    typedef enum logic {
        DECRYPT = 1'b0,
        ENCRYPT = 1'b1
    } cipher_mode_e;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_UPPER = 2'd1,
        CLS_LOWER = 2'd2
    } char_class_e;

    // Both operands are already in 0..25, so one conditional correction is enough.
    function automatic alpha_idx_t mod26_add(input alpha_idx_t idx,
                                             input alpha_idx_t key,
                                             input cipher_mode_e mode);
        logic [5:0] r;
        if (mode == ENCRYPT) begin
            r = {1'b0, idx} + {1'b0, key};
            if (r >= 6'(ALPHA_N)) begin
                r = r - 6'(ALPHA_N);
            end
        end else begin
            r = {1'b0, idx} - {1'b0, key};
            if (r[5]) begin
                r = r + 6'(ALPHA_N);
            end
        end
        return r[4:0];
    endfunction

    function automatic alpha_idx_t mod26_wrap(input logic [5:0] value);
        logic [5:0] r;
        r = value;
        if (r >= 6'(ALPHA_N)) begin
            r = r - 6'(ALPHA_N);
        end
        return r[4:0];
    endfunction

    function automatic logic [6:0] base_of(input char_class_e cls);
        return (cls == CLS_LOWER) ? 7'(LOWER_BASE) : 7'(UPPER_BASE);
    endfunction

endpackage

// File: rtl/encrypt_rolling_key.sv
// Key register for the rotate cipher: load from config has priority over stepping.
module encrypt_rolling_key
    import encrypt_cipher_pkg::*;
#(
    parameter int SHIFT_W  = 5,
    parameter int STEP_INC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               step,
    output alpha_idx_t         key
);

    logic [5:0] load_raw;
    logic [5:0] step_raw;

    // cfg_shift is at most 31 and key+STEP_INC at most 50, so a single wrap suffices.
    assign load_raw = 6'(cfg_shift);
    assign step_raw = {1'b0, key} + 6'(STEP_INC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= '0;
        end else if (cfg_load) begin
            key <= mod26_wrap(load_raw);
        end else if (step) begin
            key <= mod26_wrap(step_raw);
        end
    end

endmodule

// File: rtl/encrypt_pipe_rotate_cipher.sv
// Three-stage Caesar/rolling-key rotation of ASCII letters with valid/ready backpressure.
module encrypt_pipe_rotate_cipher
    import encrypt_cipher_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SHIFT_W  = 5,
    parameter int STEP_INC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_mode,
    input  logic               cfg_step_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_is_alpha,
    output logic [4:0]         key_cur
);

    logic        adv;
    logic        accept;
    logic        in_letter;
    logic        step;
    char_class_e in_cls;
    alpha_idx_t  in_idx;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    char_class_e       s1_cls;
    alpha_idx_t        s1_idx;
    cipher_mode_e      s1_mode;
    alpha_idx_t        s1_key;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    char_class_e       s2_cls;
    alpha_idx_t        s2_r;

    // Whole-word compares so any bit above [6:0] makes the character non-alpha.
    always_comb begin
        in_cls = CLS_OTHER;
        in_idx = '0;
        if (in_data >= DATA_W'(UPPER_BASE) && in_data <= DATA_W'(UPPER_BASE + ALPHA_N - 1)) begin
            in_cls = CLS_UPPER;
            in_idx = alpha_idx_t'(in_data[6:0] - 7'(UPPER_BASE));
        end else if (in_data >= DATA_W'(LOWER_BASE) && in_data <= DATA_W'(LOWER_BASE + ALPHA_N - 1)) begin
            in_cls = CLS_LOWER;
            in_idx = alpha_idx_t'(in_data[6:0] - 7'(LOWER_BASE));
        end
    end

    assign in_letter = (in_cls != CLS_OTHER);
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign step      = accept && in_letter && cfg_step_en;

    encrypt_rolling_key #(
        .SHIFT_W  (SHIFT_W),
        .STEP_INC (STEP_INC)
    ) u_key (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_shift (cfg_shift),
        .step      (step),
        .key       (key_cur)
    );

    // The accepted character captures the key as it stands, before any same-cycle load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_cls   <= CLS_OTHER;
            s1_idx   <= '0;
            s1_mode  <= DECRYPT;
            s1_key   <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= in_data;
                s1_cls  <= in_cls;
                s1_idx  <= in_idx;
                s1_mode <= cipher_mode_e'(cfg_mode);
                s1_key  <= key_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_cls   <= CLS_OTHER;
            s2_r     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_data;
                s2_cls  <= s1_cls;
                s2_r    <= mod26_add(s1_idx, s1_key, s1_mode);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_is_alpha <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_is_alpha <= (s2_cls != CLS_OTHER);
                out_data     <= (s2_cls == CLS_OTHER) ? s2_data
                                                      : DATA_W'(base_of(s2_cls) + 7'(s2_r));
            end
        end
    end

endmodule

// File: tb/tb_encrypt_pipe_rotate_cipher.sv
// Table-driven plus randomized bench for the rotate-cipher pipeline, with a scoreboard model.
module tb_encrypt_pipe_rotate_cipher;

    localparam int DATA_W   = 9;
    localparam int SHIFT_W  = 5;
    localparam int STEP_INC = 1;

    logic              clk;
    logic              rst;
    logic              cfg_load;
    logic [SHIFT_W-1:0] cfg_shift;
    logic              cfg_mode;
    logic              cfg_step_en;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_is_alpha;
    logic [4:0]        key_cur;

    encrypt_pipe_rotate_cipher #(
        .DATA_W   (DATA_W),
        .SHIFT_W  (SHIFT_W),
        .STEP_INC (STEP_INC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_load     (cfg_load),
        .cfg_shift    (cfg_shift),
        .cfg_mode     (cfg_mode),
        .cfg_step_en  (cfg_step_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_is_alpha (out_is_alpha),
        .key_cur      (key_cur)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [8:0] ch;
        logic       mode;
        logic [4:0] shift;
        logic [8:0] exp_data;
        logic       exp_alpha;
    } vec_t;

    typedef struct {
        logic [8:0] data;
        logic       alpha;
    } exp_t;

    vec_t vecs[16];
    exp_t exp_q[$];
    exp_t mon_item;
    int   total = 0;
    int   bad = 0;
    int   mkey = 0;
    int   ready_pct = 100;

    logic       prev_stall = 1'b0;
    logic [8:0] prev_data = '0;
    logic       prev_alpha = 1'b0;

    function automatic bit is_letter(input int c);
        return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
    endfunction

    function automatic int ref_cipher(input int c, input int key, input bit enc);
        int base;
        int idx;
        if (!is_letter(c)) return c;
        base = (c >= 97) ? 97 : 65;
        idx  = c - base;
        return enc ? base + (idx + key) % 26 : base + (idx - key + 26) % 26;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One handshake attempt per cycle; retries while backpressured and updates the key model.
    task automatic applyStimulus(input logic [8:0] ch, input logic mode, input logic step,
                                 input logic load, input logic [4:0] shift, input logic valid,
                                 input logic has_exp, input logic [8:0] exp_d, input logic exp_a);
        int   tries;
        logic acc;
        exp_t item;
        tries     = 0;
        acc       = 1'b0;
        cfg_load  = load;
        cfg_shift = shift;
        do begin
            in_valid    = valid;
            in_data     = ch;
            cfg_mode    = mode;
            cfg_step_en = step;
            out_ready   = (ready_pct >= int'($urandom_range(1, 100)));
            @(negedge clk);
            checkOutput("key_cur", int'(key_cur), mkey);
            acc = valid && in_ready;
            if (acc) begin
                item.data  = has_exp ? exp_d : 9'(ref_cipher(int'(ch), mkey, mode));
                item.alpha = has_exp ? exp_a : is_letter(int'(ch));
                exp_q.push_back(item);
            end
            if (cfg_load)
                mkey = int'(cfg_shift) % 26;
            else if (acc && step && is_letter(int'(ch)))
                mkey = (mkey + STEP_INC) % 26;
            @(posedge clk);
            #1;
            cfg_load = 1'b0;
            tries++;
        end while (valid && !acc && tries < 50);
        if (valid && !acc) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got no accept want accept of 0x%0h", ch);
        end
        in_valid = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(9'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 9'd0, 1'b0);
    endtask

    task automatic loadKey(input logic [4:0] shift);
        applyStimulus(9'd0, 1'b1, 1'b0, 1'b1, shift, 1'b0, 1'b0, 9'd0, 1'b0);
    endtask

    task automatic sendChar(input logic [8:0] ch, input logic mode, input logic step,
                            input logic [8:0] exp_d, input logic exp_a);
        applyStimulus(ch, mode, step, 1'b0, 5'd0, 1'b1, 1'b1, exp_d, exp_a);
    endtask

    task automatic drain();
        int n;
        ready_pct = 100;
        n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            idleCycle();
            n++;
        end
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    task automatic measureLatency(input logic [8:0] ch, input logic [8:0] exp_d);
        int cycles;
        ready_pct = 100;
        sendChar(ch, 1'b1, 1'b0, exp_d, 1'b1);
        cycles = 1;
        while (!out_valid && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("latency", cycles, 3);
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", int'(out_valid), 1);
                checkOutput("stall_data", int'(out_data), int'(prev_data));
                checkOutput("stall_alpha", int'(out_is_alpha), int'(prev_alpha));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h want nothing", out_data);
                end else begin
                    mon_item = exp_q.pop_front();
                    checkOutput("out_data", int'(out_data), int'(mon_item.data));
                    checkOutput("out_is_alpha", int'(out_is_alpha), int'(mon_item.alpha));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_alpha <= out_is_alpha;
        end
    end

    initial begin
        vecs[0]  = '{9'd65,  1'b1, 5'd3,  9'd68,  1'b1};
        vecs[1]  = '{9'd120, 1'b1, 5'd3,  9'd97,  1'b1};
        vecs[2]  = '{9'd97,  1'b0, 5'd1,  9'd122, 1'b1};
        vecs[3]  = '{9'd66,  1'b0, 5'd1,  9'd65,  1'b1};
        vecs[4]  = '{9'd90,  1'b1, 5'd29, 9'd67,  1'b1};
        vecs[5]  = '{9'h035, 1'b1, 5'd5,  9'h035, 1'b0};
        vecs[6]  = '{9'h020, 1'b1, 5'd5,  9'h020, 1'b0};
        vecs[7]  = '{9'd64,  1'b1, 5'd5,  9'd64,  1'b0};
        vecs[8]  = '{9'd91,  1'b1, 5'd5,  9'd91,  1'b0};
        vecs[9]  = '{9'h1C1, 1'b1, 5'd5,  9'h1C1, 1'b0};
        vecs[10] = '{9'd96,  1'b1, 5'd5,  9'd96,  1'b0};
        vecs[11] = '{9'd123, 1'b0, 5'd5,  9'd123, 1'b0};
        vecs[12] = '{9'd122, 1'b1, 5'd25, 9'd121, 1'b1};
        vecs[13] = '{9'd77,  1'b0, 5'd0,  9'd77,  1'b1};
        vecs[14] = '{9'd99,  1'b0, 5'd5,  9'd120, 1'b1};
        vecs[15] = '{9'h161, 1'b0, 5'd5,  9'h161, 1'b0};

        rst = 1'b1;
        cfg_load = 1'b0;
        cfg_shift = '0;
        cfg_mode = 1'b0;
        cfg_step_en = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_out_is_alpha", int'(out_is_alpha), 0);
        checkOutput("reset_key_cur", int'(key_cur), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 1);

        // Encrypt basic with latency measurement.
        ready_pct = 100;
        loadKey(5'd3);
        measureLatency(9'd65, 9'd68);
        sendChar(9'd120, 1'b1, 1'b0, 9'd97, 1'b1);
        drain();

        foreach (vecs[i]) begin
            loadKey(vecs[i].shift);
            sendChar(vecs[i].ch, vecs[i].mode, 1'b0, vecs[i].exp_data, vecs[i].exp_alpha);
        end
        drain();

        // Rolling key, including non-alpha not stepping and the 25 -> 0 wrap.
        loadKey(5'd0);
        sendChar(9'd65, 1'b1, 1'b1, 9'd65, 1'b1);
        sendChar(9'd65, 1'b1, 1'b1, 9'd66, 1'b1);
        sendChar(9'd33, 1'b1, 1'b1, 9'd33, 1'b0);
        sendChar(9'd65, 1'b1, 1'b1, 9'd67, 1'b1);
        checkOutput("rolling_key_end", int'(key_cur), 3);
        loadKey(5'd25);
        sendChar(9'd65, 1'b1, 1'b1, 9'd90, 1'b1);
        sendChar(9'd65, 1'b1, 1'b1, 9'd65, 1'b1);
        checkOutput("rolling_wrap_key", int'(key_cur), 1);
        drain();

        // Load colliding with accept: the letter keeps the old key.
        loadKey(5'd2);
        applyStimulus(9'd65, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 9'd67, 1'b1);
        sendChar(9'd65, 1'b1, 1'b0, 9'd72, 1'b1);
        checkOutput("collision_key", int'(key_cur), 7);
        drain();

        // Ten letters with a four-cycle downstream stall after the fourth.
        loadKey(5'd1);
        for (int i = 0; i < 4; i++)
            sendChar(9'(97 + i), 1'b1, 1'b0, 9'(98 + i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = 9'd101;
            cfg_mode  = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            checkOutput("stall_in_ready", int'(in_ready), 0);
            checkOutput("stall_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int i = 4; i < 10; i++)
            sendChar(9'(97 + i), 1'b1, 1'b0, 9'(98 + i), 1'b1);
        drain();

        // Randomized traffic checked against the model.
        ready_pct = 70;
        for (int i = 0; i < 300; i++) begin
            logic [8:0] ch;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      ch = 9'(65 + $urandom_range(0, 25));
            else if (sel < 8) ch = 9'(97 + $urandom_range(0, 25));
            else              ch = 9'($urandom_range(0, 511));
            applyStimulus(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 4) != 0), 1'b0, 9'd0, 1'b0);
        end
        drain();

        // Reset with characters in flight.
        loadKey(5'd4);
        applyStimulus(9'd97, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 9'd0, 1'b0);
        applyStimulus(9'd98, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 9'd0, 1'b0);
        applyStimulus(9'd99, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 9'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_key_cur", int'(key_cur), 0);
        checkOutput("midrst_out_data", int'(out_data), 0);
        exp_q.delete();
        mkey = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("midrst_no_stale", int'(out_valid), 0);
        end
        measureLatency(9'd66, 9'd66);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
